// File: rtl/clk_div_pkg.sv
// Shared types and default constants for the two-channel clock divider.
// No logic lives here.
// Imported by clk_div_chan and the clk_div_ctrl top.
package clk_div_pkg;

    // Width of the counters and terminal counts, plus the terminal counts used after reset.
    localparam int CNT_W_DEF    = 7;
    localparam int DIV1_RST_DEF = 5;    // 12-cycle period
    localparam int DIV2_RST_DEF = 10;   // 22-cycle period

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } slot_state_e;

    // The held config word. The top-level CNT_W must equal CNT_W_DEF.
    typedef struct packed {
        logic                 sel;
        logic                 en;
        logic [CNT_W_DEF-1:0] half;
    } cfg_word_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: a half-period counter, a registered square wave and a rising-edge clock enable.
// Latency: clk_o and ce_o are registered. An apply takes effect in the cycle after it is asserted.
// Backpressure: none. The parent asserts apply_i only when run_o is 0 or bnd_o is 1.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_N = '0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             apply_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_o,
    output logic             ce_o,
    output logic             run_o,
    output logic             bnd_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             out_q, out_d;
    logic             ce_q, ce_d;
    chan_state_e      st_q, st_d;

    // The period boundary is the falling toggle. It is the only point where a running channel may be retimed.
    assign bnd_o = (st_q == RUN) && (cnt_q == n_q) && out_q;
    assign clk_o = out_q;
    assign ce_o  = ce_q;
    assign run_o = (st_q == RUN);

    // Next state: count and toggle while running. An apply overrides this and restarts the channel from cnt = 0 with out low.
    always_comb begin
        cnt_d = cnt_q;
        n_d   = n_q;
        out_d = out_q;
        ce_d  = 1'b0;
        st_d  = st_q;
        if (st_q == RUN) begin
            if (cnt_q == n_q) begin
                cnt_d = '0;
                out_d = ~out_q;
                ce_d  = ~out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // At a boundary the toggle is already falling, so forcing out low completes that toggle.
        if (apply_i) begin
            n_d   = half_i;
            cnt_d = '0;
            out_d = 1'b0;
            ce_d  = 1'b0;
            st_d  = en_i ? RUN : STOP;
        end
    end

    // Channel state register. Reset starts the channel running at its reset terminal count.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
            n_q   <= RST_N;
            out_q <= 1'b0;
            ce_q  <= 1'b0;
            st_q  <= RUN;
        end else begin
            cnt_q <= cnt_d;
            n_q   <= n_d;
            out_q <= out_d;
            ce_q  <= ce_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Two-channel divider controller: a single-entry config slot that steers each update to its channel.
// Latency: a stopped target is updated 1 cycle after the transfer. A running target is updated at its next period boundary.
// Backpressure: cfg_ready is low while a word is pending. cfg_valid is ignored during that time.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DIV1_RST = DIV1_RST_DEF,
    parameter int DIV2_RST = DIV2_RST_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out_1,
    output logic             clk_out_2,
    output logic             ce_1,
    output logic             ce_2,
    output logic             run_1,
    output logic             run_2
);

    slot_state_e slot_q, slot_d;
    cfg_word_t   word_q, word_d;
    logic        bnd_1, bnd_2;
    logic        apply_1, apply_2;

    assign cfg_ready = (slot_q == IDLE);

    // Apply only at a safe point: immediately if the target is stopped, otherwise at its falling toggle.
    assign apply_1 = (slot_q == PEND) && !word_q.sel && (!run_1 || bnd_1);
    assign apply_2 = (slot_q == PEND) &&  word_q.sel && (!run_2 || bnd_2);

    // Slot next state: capture a word on transfer and release the slot once it has been applied.
    always_comb begin
        slot_d = slot_q;
        word_d = word_q;
        if (slot_q == IDLE) begin
            if (cfg_valid) begin
                word_d.sel  = cfg_sel;
                word_d.en   = cfg_en;
                word_d.half = cfg_half;
                slot_d      = PEND;
            end
        end else if (apply_1 || apply_2) begin
            slot_d = IDLE;
        end
    end

    // Slot register. Reset discards any pending word.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            slot_q <= IDLE;
            word_q <= '0;
        end else begin
            slot_q <= slot_d;
            word_q <= word_d;
        end
    end

    clk_div_chan #(
        .CNT_W (CNT_W),
        .RST_N (CNT_W'(DIV1_RST))
    ) u_chan_1 (
        .clk_in  (clk_in),
        .rst     (rst),
        .apply_i (apply_1),
        .en_i    (word_q.en),
        .half_i  (word_q.half),
        .clk_o   (clk_out_1),
        .ce_o    (ce_1),
        .run_o   (run_1),
        .bnd_o   (bnd_1)
    );

    clk_div_chan #(
        .CNT_W (CNT_W),
        .RST_N (CNT_W'(DIV2_RST))
    ) u_chan_2 (
        .clk_in  (clk_in),
        .rst     (rst),
        .apply_i (apply_2),
        .en_i    (word_q.en),
        .half_i  (word_q.half),
        .clk_o   (clk_out_2),
        .ce_o    (ce_2),
        .run_o   (run_2),
        .bnd_o   (bnd_2)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl.
// A phase-position model is compared with the DUT on every cycle, and literal period and latency checks pin the model.
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled on the falling edge.
module tb_clk_div_ctrl;

    localparam int CW = 7;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_sel = 1'b0;
    logic          cfg_en = 1'b0;
    logic [CW-1:0] cfg_half = '0;
    logic          cfg_ready;
    logic          clk_out_1, clk_out_2, ce_1, ce_2, run_1, run_2;

    clk_div_ctrl dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_en    (cfg_en),
        .cfg_half  (cfg_half),
        .clk_out_1 (clk_out_1),
        .clk_out_2 (clk_out_2),
        .ce_1      (ce_1),
        .ce_2      (ce_2),
        .run_1     (run_1),
        .run_2     (run_2)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each channel is a position p inside a period of 2(N+1) cycles.
    // The output is high in the second half of the period. The boundary is the last position of the period.
    int m_n[2];
    int m_p[2];
    bit m_run[2];
    bit m_pend;
    int m_sel;
    bit m_en;
    int m_half;

    function automatic bit m_out(input int c);
        return m_run[c] && (m_p[c] >= m_n[c] + 1);
    endfunction

    function automatic bit m_ce(input int c);
        return m_run[c] && (m_p[c] == m_n[c] + 1);
    endfunction

    always @(posedge clk_in) begin : model_step
        bit appl [2];
        cyc <= cyc + 1;
        if (rst) begin
            m_n[0] = 5;  m_n[1] = 10;
            m_p[0] = 0;  m_p[1] = 0;
            m_run[0] = 1; m_run[1] = 1;
            m_pend = 0;
        end else begin
            appl[0] = 0; appl[1] = 0;
            if (m_pend && (!m_run[m_sel] || m_p[m_sel] == 2 * (m_n[m_sel] + 1) - 1))
                appl[m_sel] = 1;
            for (int c = 0; c < 2; c++) begin
                if (appl[c]) begin
                    m_n[c] = m_half; m_run[c] = m_en; m_p[c] = 0;
                end else if (m_run[c]) begin
                    m_p[c] = (m_p[c] + 1) % (2 * (m_n[c] + 1));
                end
            end
            if (appl[0] || appl[1]) m_pend = 0;
            else if (cfg_valid && !m_pend) begin
                m_pend = 1; m_sel = int'(cfg_sel); m_en = cfg_en; m_half = int'(cfg_half);
            end
        end
    end

    // Compare against the model on every cycle and record the cycles of rising and falling edges.
    int  rise1[$], rise2[$], fall1[$];
    logic p1 = 1'b0, p2 = 1'b0;
    always @(negedge clk_in) begin
        if (cyc > 0) begin
            check("clk_out_1", clk_out_1, m_out(0));
            check("clk_out_2", clk_out_2, m_out(1));
            check("ce_1", ce_1, m_ce(0));
            check("ce_2", ce_2, m_ce(1));
            check("run_1", run_1, m_run[0]);
            check("run_2", run_2, m_run[1]);
            check("cfg_ready", cfg_ready, !m_pend);
        end
        if (clk_out_1 && !p1) rise1.push_back(cyc);
        if (!clk_out_1 && p1) fall1.push_back(cyc);
        if (clk_out_2 && !p2) rise2.push_back(cyc);
        p1 = clk_out_1;
        p2 = clk_out_2;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Hold the word until it is accepted, then drop valid. On return the transfer edge has just passed.
    task automatic send(input logic sel, input logic en, input logic [CW-1:0] half);
        bit got = 0;
        cfg_valid = 1'b1; cfg_sel = sel; cfg_en = en; cfg_half = half;
        for (int i = 0; i < 200; i++) begin
            if (cfg_ready) begin got = 1; break; end
            tick(1);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_timeout: cfg_ready stayed 0, expected 1 within 200 cycles");
        end
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk1"}, clk_out_1, 0);
        check({tag, "_clk2"}, clk_out_2, 0);
        check({tag, "_ce1"}, ce_1, 0);
        check({tag, "_ce2"}, ce_2, 0);
        check({tag, "_run1"}, run_1, 1);
        check({tag, "_run2"}, run_2, 1);
        check({tag, "_rdy"}, cfg_ready, 1);
    endtask

    // Release reset, then check the first-edge delays and the default periods of both channels.
    task automatic release_and_check_default(input string tag);
        int r0;
        rst = 1'b0;
        r0 = cyc;
        rise1.delete(); rise2.delete(); fall1.delete();
        tick(60);
        check({tag, "_first_rise1"}, rise1[0] - r0, 6);
        check({tag, "_period1"}, rise1[1] - rise1[0], 12);
        check({tag, "_period1b"}, rise1[2] - rise1[1], 12);
        check({tag, "_high1"}, fall1[0] - rise1[0], 6);
        check({tag, "_first_rise2"}, rise2[0] - r0, 11);
        check({tag, "_period2"}, rise2[1] - rise2[0], 22);
    endtask

    initial begin
        int n;
        int w;

        // Reset, no configuration.
        tick(3);
        check_reset_vals("rst");
        release_and_check_default("dflt");

        // Retime channel 1 to a period of 4 while clk_out_1 is in its high phase.
        w = 0;
        while (!clk_out_1 && w < 50) begin tick(1); w++; end
        check("wait_high1", clk_out_1, 1);
        tick(2);
        send(1'b0, 1'b1, 7'd1);
        check("w1_ready_low", cfg_ready, 0);
        tick(40);
        n = rise1.size();
        check("w1_period4", rise1[n-1] - rise1[n-2], 4);
        n = rise2.size();
        check("w1_period2_kept", rise2[n-1] - rise2[n-2], 22);

        // Stop channel 2.
        send(1'b1, 1'b0, 7'd3);
        tick(40);
        n = rise2.size();
        tick(30);
        check("stop_no_rise2", rise2.size(), n);
        check("stop_run2", run_2, 0);
        check("stop_clk2", clk_out_2, 0);

        // Restart channel 2 at clk_in/2. The update is applied at the edge after the transfer edge.
        send(1'b1, 1'b1, 7'd0);
        check("re_ready_low", cfg_ready, 0);
        tick(1);
        check("re_ready_back", cfg_ready, 1);
        check("re_run2", run_2, 1);
        check("re_clk2_low", clk_out_2, 0);
        tick(1);
        check("re_clk2_high", clk_out_2, 1);
        check("re_ce2_high", ce_2, 1);
        tick(1);
        check("re_clk2_low2", clk_out_2, 0);
        check("re_ce2_low", ce_2, 0);
        tick(10);

        // Back-to-back words: the second must wait for the first and land after it.
        send(1'b0, 1'b1, 7'd3);
        check("b2b_ready_low", cfg_ready, 0);
        send(1'b0, 1'b1, 7'd2);
        tick(60);
        n = rise1.size();
        check("b2b_period6", rise1[n-1] - rise1[n-2], 6);

        // Reset while a word is pending drops the word.
        send(1'b0, 1'b0, 7'd9);
        check("rp_pending", cfg_ready, 0);
        rst = 1'b1;
        tick(1);
        check_reset_vals("rp");
        release_and_check_default("rp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
